// File: rtl/tc_pkg.sv
// Shared TinyComp definitions: word width, input-arbiter state encoding and a clog2 helper.
package tc_pkg;

  localparam int TC_WORD_W = 32;

  typedef enum logic {
    TC_ARB_EMPTY = 1'b0,
    TC_ARB_FULL  = 1'b1
  } tc_arb_state_e;

  function automatic int tc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tc_input_arbiter_if.sv
// Producer/core-side bundle of the TinyComp input arbiter.
// The slave modport is the arbiter; the master modport is the producers plus the core.
interface tc_input_arbiter_if
  import tc_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRC_W = tc_clog2(NREQ)
);
  logic [NREQ-1:0]           ReqValid;
  logic [NREQ*TC_WORD_W-1:0] ReqData;
  logic [NREQ-1:0]           ReqReady;
  logic [TC_WORD_W-1:0]      InData;
  logic                      InRdy;
  logic                      InStrobe;
  logic [SRC_W-1:0]          CurSrc;
  logic                      Underrun;

  modport master (
    output ReqValid, ReqData, InStrobe,
    input  ReqReady, InData, InRdy, CurSrc, Underrun
  );

  modport slave (
    input  ReqValid, ReqData, InStrobe,
    output ReqReady, InData, InRdy, CurSrc, Underrun
  );
endinterface

// File: rtl/tc_rr_picker.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping modulo NREQ.
// Purely combinational (zero latency); no backpressure of its own.
module tc_rr_picker
  import tc_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRC_W = tc_clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [SRC_W-1:0] id,
  output logic             any
);

  always_comb begin
    int               pos;
    logic [SRC_W-1:0] idx;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    pos = 0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = SRC_W'(pos);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/tc_input_arbiter.sv
// Round-robin shares the TinyComp input port among NREQ producers through a one-entry buffer; word visible 1 cycle after grant.
// Accepts a word when empty or when the core strobes (refill without bubble); ReqReady is 0 while full and idle. Option: TC_IN_ARB_TAG_EN.
module tc_input_arbiter
  import tc_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRC_W = tc_clog2(NREQ)
) (
  input  logic               Ph0,
  input  logic               Reset_n,
  tc_input_arbiter_if.slave  bus
);

  tc_arb_state_e        state_q, state_d;
  logic [TC_WORD_W-1:0] hold_q, hold_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [SRC_W-1:0]     cur_src_q, cur_src_d;
  logic                 underrun_q, underrun_d;

  logic [NREQ-1:0]      gnt;
  logic [SRC_W-1:0]     pick_id;
  logic                 pick_any;
  logic [TC_WORD_W-1:0] pick_data;
  logic                 acc;
  logic                 xfer;

  tc_rr_picker #(.NREQ(NREQ), .SRC_W(SRC_W)) u_picker (
    .req (bus.ReqValid),
    .ptr (ptr_q),
    .gnt (gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // A full buffer can take a new word only at the edge the core consumes the old one.
  assign acc  = (state_q == TC_ARB_EMPTY) || bus.InStrobe;
  assign xfer = acc && pick_any;

  assign bus.ReqReady = (acc && Reset_n) ? gnt : '0;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == SRC_W'(i)) pick_data = bus.ReqData[i*TC_WORD_W +: TC_WORD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;
    cur_src_d  = cur_src_q;
    underrun_d = underrun_q || ((state_q == TC_ARB_EMPTY) && bus.InStrobe);
    if (xfer) begin
      state_d   = TC_ARB_FULL;
      hold_d    = pick_data;
      cur_src_d = pick_id;
      ptr_d     = (pick_id == SRC_W'(NREQ - 1)) ? '0 : pick_id + SRC_W'(1);
    end else if ((state_q == TC_ARB_FULL) && bus.InStrobe) begin
      state_d = TC_ARB_EMPTY;
      hold_d  = '0;
    end
  end

  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= TC_ARB_EMPTY;
      hold_q     <= '0;
      ptr_q      <= '0;
      cur_src_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      cur_src_q  <= cur_src_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.InRdy    = (state_q == TC_ARB_FULL);
  assign bus.CurSrc   = cur_src_q;
  assign bus.Underrun = underrun_q;

`ifdef TC_IN_ARB_TAG_EN
  // Source id replaces the top payload bits so the core can tell producers apart.
  assign bus.InData = (state_q == TC_ARB_FULL) ? {cur_src_q, hold_q[TC_WORD_W-1-SRC_W:0]} : '0;
`else
  assign bus.InData = hold_q;
`endif

endmodule
